// File: rtl/scratchpad_bank_arbiter_pkg.sv
// Shared constants and types for the scratchpad bank front ends.
// Widths here describe one 256 x 32-bit bank.
package scratchpad_pkg;

  localparam int SPAD_ADDR_W = 8;
  localparam int SPAD_DATA_W = 32;
  localparam int SPAD_DEPTH  = 256;
  localparam int SPAD_IDX_W  = 2;

  typedef struct packed {
    logic                   we;
    logic [SPAD_ADDR_W-1:0] addr;
    logic [SPAD_DATA_W-1:0] wdata;
  } spad_req_t;

  typedef struct packed {
    logic                  valid;
    logic [SPAD_IDX_W-1:0] idx;
    logic                  we;
  } spad_tag_t;

endpackage

// File: rtl/scratchpad_bank_arbiter_if.sv
// Master-side request/response bundle for the scratchpad bank arbiter.
// Each master owns one lane of the packed arrays; the response bus is shared.
interface scratchpad_bank_arbiter_if
  import scratchpad_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = SPAD_ADDR_W,
  parameter int DATA_W = SPAD_DATA_W
);

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0]             req_we;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]             resp_valid;
  logic                        resp_we;
  logic [DATA_W-1:0]           resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_we, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_we, resp_rdata
  );

endinterface

// File: rtl/scratchpad_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Shared by the bank arbiters; holds no state of its own.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand     = (int'(ptr) + k) % N;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        gnt           = '0;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/scratchpad_bank_arbiter.sv
// Round-robin front end for one scratchpad bank: one access per cycle,
// one-cycle response routed back to the issuing master via a tag register.
module scratchpad_bank_arbiter
  import scratchpad_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = SPAD_ADDR_W,
  parameter int DATA_W = SPAD_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  scratchpad_bank_arbiter_if.slave  req_if,
  output logic                      bank_ren,
  output logic                      bank_wen,
  output logic [ADDR_W-1:0]         bank_addr,
  output logic [DATA_W-1:0]         bank_wdata,
  input  logic [DATA_W-1:0]         bank_rdata,
  input  logic                      bank_rvalid,
  output logic                      err_orphan
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDX_W-1:0] ptr;
  logic [NREQ-1:0]  req_live;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             accept;
  spad_req_t        sel;
  spad_tag_t        tag;
  logic             resp_hit;
  logic [NREQ-1:0]  resp_valid_c;

  // Requests are ignored while rst is high so nothing is granted in that cycle.
  assign req_live = req_if.req_valid & {NREQ{~rst}};

  rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_rr (
    .req     (req_live),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign accept           = |gnt;
  assign req_if.req_ready = gnt;

  always_comb begin
    sel        = '0;
    bank_ren   = 1'b0;
    bank_wen   = 1'b0;
    bank_addr  = '0;
    bank_wdata = '0;
    if (accept) begin
      sel.we     = req_if.req_we[gnt_idx];
      sel.addr   = SPAD_ADDR_W'(req_if.req_addr[gnt_idx]);
      sel.wdata  = SPAD_DATA_W'(req_if.req_wdata[gnt_idx]);
      bank_ren   = ~sel.we;
      bank_wen   = sel.we;
      bank_addr  = ADDR_W'(sel.addr);
      bank_wdata = DATA_W'(sel.wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      tag <= '0;
    end else begin
      tag.valid <= accept;
      if (accept) begin
        ptr     <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        tag.idx <= SPAD_IDX_W'(gnt_idx);
        tag.we  <= sel.we;
      end
    end
  end

  // A tag left over from the cycle before a reset must not leak a response.
  assign resp_hit = bank_rvalid & tag.valid & ~rst;

  always_comb begin
    resp_valid_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid_c[i] = resp_hit & (tag.idx == SPAD_IDX_W'(i));
    end
  end

  assign req_if.resp_valid = resp_valid_c;
  assign req_if.resp_we    = tag.we & ~rst;
  assign req_if.resp_rdata = bank_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_orphan <= 1'b0;
    end else if (bank_rvalid & ~tag.valid) begin
      err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scratchpad_bank_arbiter.sv
// Directed bench for scratchpad_bank_arbiter with a write-through bank model
// and a response scoreboard drained by an independent monitor.
module tb_scratchpad_bank_arbiter;
  import scratchpad_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        bank_ren, bank_wen;
  logic [7:0]  bank_addr;
  logic [31:0] bank_wdata;
  logic [31:0] bank_rdata;
  logic        bank_rvalid;
  logic        bank_rvalid_q;
  logic        force_rvalid;
  logic        err_orphan;
  logic [31:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0]  oh;
    logic        we;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  scratchpad_bank_arbiter_if #(.NREQ(2), .ADDR_W(8), .DATA_W(32)) bus ();

  scratchpad_bank_arbiter #(.NREQ(2), .ADDR_W(8), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_if      (bus),
    .bank_ren    (bank_ren),
    .bank_wen    (bank_wen),
    .bank_addr   (bank_addr),
    .bank_wdata  (bank_wdata),
    .bank_rdata  (bank_rdata),
    .bank_rvalid (bank_rvalid),
    .err_orphan  (err_orphan)
  );

  always #5 clk = ~clk;

  // Write-through bank: a write echoes its data, a read returns stored data.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  end
  always @(posedge clk) begin
    bank_rvalid_q <= bank_ren | bank_wen;
    if (bank_wen) begin
      mem[bank_addr] <= bank_wdata;
      bank_rdata     <= bank_wdata;
    end else if (bank_ren) begin
      bank_rdata <= mem[bank_addr];
    end
  end
  assign bank_rvalid = bank_rvalid_q | force_rvalid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every response strobe must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.resp_valid !== 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", {62'h0, bus.resp_valid}, 64'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp", {bus.resp_valid, bus.resp_we, bus.resp_rdata},
              {e.oh, e.we, e.data});
        end
      end
    end
  end

  task automatic set_req(input logic [1:0] v, input logic [1:0] we,
                         input logic [7:0] a0, input logic [31:0] d0,
                         input logic [7:0] a1, input logic [31:0] d1);
    bus.req_valid    = v;
    bus.req_we       = we;
    bus.req_addr[0]  = a0;
    bus.req_wdata[0] = d0;
    bus.req_addr[1]  = a1;
    bus.req_wdata[1] = d1;
  endtask

  task automatic idle();
    set_req(2'b00, 2'b00, 8'h0, 32'h0, 8'h0, 32'h0);
  endtask

  // One cycle: check the grant side mid-cycle, queue the response it implies.
  task automatic cyc(input string name, input logic [1:0] rdy, input logic ren,
                     input logic wen, input logic [7:0] addr,
                     input logic push, input logic rwe, input logic [31:0] rdata);
    @(negedge clk);
    chk({name, "_ready"}, {62'h0, bus.req_ready}, {62'h0, rdy});
    chk({name, "_bank"}, {54'h0, bank_ren, bank_wen, bank_addr},
        {54'h0, ren, wen, addr});
    if (push) begin
      exp_t e;
      e.oh = rdy; e.we = rwe; e.data = rdata;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    force_rvalid = 1'b0;
    idle();
    repeat (2) begin @(posedge clk); #1; end
    // Requests during reset are never granted and outputs stay quiet.
    set_req(2'b11, 2'b00, 8'h05, 32'h0, 8'h05, 32'h0);
    @(negedge clk);
    chk("rst_ready", {62'h0, bus.req_ready}, 64'h0);
    chk("rst_outs", {60'h0, bank_ren, bank_wen, |bus.resp_valid, err_orphan}, 64'h0);
    chk("rst_addr", {56'h0, bank_addr}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read: m0 writes word 5, m1 reads it back.
    set_req(2'b01, 2'b01, 8'h05, 32'hDEADBEEF, 8'h00, 32'h0);
    cyc("wr5", 2'b01, 1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 32'hDEADBEEF);
    set_req(2'b10, 2'b00, 8'h00, 32'h0, 8'h05, 32'h0);
    cyc("rd5", 2'b10, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 32'hDEADBEEF);
    idle();
    cyc("idle0", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);

    // Contention fairness straight after a reset.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(2'b11, 2'b00, 8'h05, 32'h0, 8'h20, 32'h0);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) cyc("fair_m0", 2'b01, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 32'hDEADBEEF);
      else            cyc("fair_m1", 2'b10, 1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 32'h0);
    end

    // Write echo then read-after-write from the other master.
    set_req(2'b01, 2'b01, 8'hFF, 32'h12345678, 8'h00, 32'h0);
    cyc("wrff", 2'b01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 32'h12345678);
    set_req(2'b10, 2'b00, 8'h00, 32'h0, 8'hFF, 32'h0);
    cyc("rdff", 2'b10, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 32'h12345678);
    idle();
    cyc("idle1", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);

    // Lone requester is granted every cycle; ptr wraps back to 0.
    set_req(2'b10, 2'b00, 8'h00, 32'h0, 8'h05, 32'h0);
    repeat (4) cyc("solo_m1", 2'b10, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 32'hDEADBEEF);
    idle();
    cyc("idle2", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    set_req(2'b11, 2'b00, 8'h05, 32'h0, 8'h20, 32'h0);
    cyc("ptr0", 2'b01, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 32'hDEADBEEF);
    set_req(2'b01, 2'b00, 8'h05, 32'h0, 8'h00, 32'h0);
    repeat (2) cyc("solo_m0", 2'b01, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 32'hDEADBEEF);

    // Reset right after an acceptance: response suppressed, ptr back to 0.
    cyc("pre_rst", 2'b01, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    set_req(2'b11, 2'b00, 8'h05, 32'h0, 8'h20, 32'h0);
    @(negedge clk);
    chk("midrst_resp", {62'h0, bus.resp_valid}, 64'h0);
    chk("midrst_ready", {62'h0, bus.req_ready}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("post_rst", 2'b01, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 32'hDEADBEEF);
    idle();
    cyc("idle3", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);

    // Orphan response: flagged next cycle, sticky until reset, never routed.
    force_rvalid = 1'b1;
    @(negedge clk);
    chk("orphan_pre", {63'h0, err_orphan}, 64'h0);
    @(posedge clk); #1;
    force_rvalid = 1'b0;
    @(negedge clk);
    chk("orphan_set", {63'h0, err_orphan}, 64'h1);
    @(posedge clk); #1;
    set_req(2'b10, 2'b00, 8'h00, 32'h0, 8'h05, 32'h0);
    cyc("orphan_rd", 2'b10, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 32'hDEADBEEF);
    idle();
    repeat (2) cyc("idle4", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("orphan_sticky", {63'h0, err_orphan}, 64'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("orphan_clr", {63'h0, err_orphan}, 64'h0);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
